// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : UART receive FIFO with per-entry error flags, FWFT read port,
//               level/threshold status and sticky overflow/underflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int MAX_UART_DATA_W = 8,
    parameter int FIFO_DEPTH      = 16,
    parameter int FIFO_ADDR_W     = 4,
    parameter int FIFO_LEVEL_W    = 5
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       fifo_en_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [MAX_UART_DATA_W-1:0] push_data_i,
    input  logic                       push_parity_err_i,
    input  logic                       push_stop_err_i,
    input  logic                       pop_i,
    input  logic [FIFO_LEVEL_W-1:0]    thresh_i,
    output logic [MAX_UART_DATA_W-1:0] rd_data_o,
    output logic                       rd_parity_err_o,
    output logic                       rd_stop_err_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [FIFO_LEVEL_W-1:0]    level_o,
    output logic                       thresh_irq_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);

    localparam int                   c_ENTRY_W = MAX_UART_DATA_W + 2;
    localparam logic [FIFO_LEVEL_W-1:0] c_FULL_LVL = FIFO_LEVEL_W'(FIFO_DEPTH);

    logic [c_ENTRY_W-1:0]    r_mem [FIFO_DEPTH];
    logic [FIFO_ADDR_W-1:0]  r_wr_ptr;
    logic [FIFO_ADDR_W-1:0]  r_rd_ptr;
    logic [FIFO_LEVEL_W-1:0] r_level;
    logic                    r_overflow;
    logic                    r_underflow;

    logic                    w_clear;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_do_push;
    logic                    w_do_pop;
    logic [c_ENTRY_W-1:0]    w_head;

    assign w_clear = !fifo_en_i || flush_i;
    assign w_full  = (r_level == c_FULL_LVL);
    assign w_empty = (r_level == '0);

    // A pop on a full FIFO frees the slot the simultaneous push needs.
    assign w_do_pop  = pop_i && !w_empty;
    assign w_do_push = push_i && (!w_full || pop_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (w_clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + FIFO_ADDR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_ADDR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_level <= r_level + FIFO_LEVEL_W'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_level <= r_level - FIFO_LEVEL_W'(1);
            end
            if (push_i && w_full && !pop_i) begin
                r_overflow <= 1'b1;
            end
            if (pop_i && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Storage is deliberately left out of reset; outputs are masked while empty.
    always_ff @(posedge clk_i) begin
        if (w_do_push && !w_clear) begin
            r_mem[r_wr_ptr] <= {push_stop_err_i, push_parity_err_i, push_data_i};
        end
    end

    assign w_head = w_empty ? '0 : r_mem[r_rd_ptr];

    assign rd_data_o       = w_head[MAX_UART_DATA_W-1:0];
    assign rd_parity_err_o = w_head[MAX_UART_DATA_W];
    assign rd_stop_err_o   = w_head[MAX_UART_DATA_W+1];
    assign full_o          = w_full;
    assign empty_o         = w_empty;
    assign level_o         = r_level;
    assign thresh_irq_o    = (thresh_i != '0) && (r_level >= thresh_i);
    assign overflow_o      = r_overflow;
    assign underflow_o     = r_underflow;

endmodule
`default_nettype wire
